// File: rtl/otp_decryptor.sv
// rtl/otp_decryptor.sv - one-time-pad decryptor with consume-on-use pad store (optional OTP_ZEROIZE_EN)
module otp_decryptor #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  pad_we,
  input  logic [IDX_W-1:0]      pad_idx,
  input  logic [DATA_W-1:0]     pad_data,
  input  logic                  ct_valid,
  output logic                  ct_ready,
  input  logic [DATA_W-1:0]     ct_data,
  input  logic [IDX_W-1:0]      ct_idx,
  output logic                  pt_valid,
  input  logic                  pt_ready,
  output logic [DATA_W-1:0]     pt_data,
  output logic [IDX_W-1:0]      pt_idx,
  output logic                  pt_err,
  output logic                  err_pulse,
  output logic [CNT_W-1:0]      err_count,
  output logic [(1<<IDX_W)-1:0] pad_avail
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]    avail_q, avail_d;
  logic [DATA_W-1:0]   pt_data_q, pt_data_d;
  logic [IDX_W-1:0]    pt_idx_q, pt_idx_d;
  logic                pt_err_q, pt_err_d;
  logic                err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;

  logic accept;
  logic pad_wr;
  logic hit;
  logic miss_err;
  logic ovw_err;
  logic any_err;

  // Handshake and error classification; a same-cycle consume of the written
  // entry makes the write a legal refill rather than an overwrite.
  assign ct_ready = en & (~pt_valid | pt_ready);
  assign accept   = ct_valid & ct_ready;
  assign pad_wr   = pad_we & en;
  assign hit      = avail_q[ct_idx];
  assign miss_err = accept & ~hit;
  assign ovw_err  = pad_wr & avail_q[pad_idx] & ~(accept & (ct_idx == pad_idx));
  assign any_err  = miss_err | ovw_err;

  // Output-beat state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output-beat next state: a new accept always (re)fills, a drain alone empties
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL: begin
        if (accept)        state_d = S_FULL;
        else if (pt_ready) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Output-beat state decode
  always_comb begin
    pt_valid = (state_q == S_FULL);
  end

  // Pad store update: consume first, then a write to the same index wins
  always_comb begin
    mem_d   = mem_q;
    avail_d = avail_q;
    if (accept) begin
      avail_d[ct_idx] = 1'b0;
`ifdef OTP_ZEROIZE_EN
      if (hit) mem_d[ct_idx] = '0;
`endif
    end
    if (pad_wr) begin
      mem_d[pad_idx]   = pad_data;
      avail_d[pad_idx] = 1'b1;
    end
  end

  // Output payload and error bookkeeping; payload holds unless a beat is accepted
  always_comb begin
    pt_data_d   = pt_data_q;
    pt_idx_d    = pt_idx_q;
    pt_err_d    = pt_err_q;
    if (accept) begin
      pt_data_d = hit ? (ct_data ^ mem_q[ct_idx]) : '0;
      pt_idx_d  = ct_idx;
      pt_err_d  = ~hit;
    end
    err_pulse_d = any_err;
    err_count_d = err_count_q;
    if (any_err && (err_count_q != {CNT_W{1'b1}})) err_count_d = err_count_q + CNT_ONE;
  end

  // Datapath and pad store registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      avail_q     <= '0;
      pt_data_q   <= '0;
      pt_idx_q    <= '0;
      pt_err_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      avail_q     <= avail_d;
      pt_data_q   <= pt_data_d;
      pt_idx_q    <= pt_idx_d;
      pt_err_q    <= pt_err_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign pt_data   = pt_data_q;
  assign pt_idx    = pt_idx_q;
  assign pt_err    = pt_err_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign pad_avail = avail_q;

endmodule
